// File: rtl/mem_wb_pipeline.sv
// EX/MEM and MEM/WB pipeline registers with a timed data-memory handshake.
// A slow load/store stalls upstream until the memory answers or the wait limit expires.
module mem_wb_pipeline #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ex_valid_i,
    input  logic [4:0]  ex_reg_wr_addr_i,
    input  logic        ex_reg_wr_sig_i,
    input  logic [1:0]  ex_data_dest_i,
    input  logic [31:0] ex_alu_result_i,
    input  logic [31:0] ex_pc_plus4_i,
    input  logic [31:0] ex_mem_wr_data_i,
    input  logic        ex_mem_rd_i,
    input  logic        ex_mem_wr_i,
    input  logic        flush_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ready_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic        dmem_err_o,
    output logic [4:0]  ex_mem_reg_wr_addr_o,
    output logic        ex_mem_reg_wr_sig_o,
    output logic [1:0]  ex_mem_data_dest_o,
    output logic [31:0] ex_mem_alu_result_o,
    output logic [31:0] ex_mem_pc_plus4_o,
    output logic [4:0]  mem_wb_reg_wr_addr_o,
    output logic        mem_wb_reg_wr_sig_o,
    output logic [1:0]  mem_wb_data_dest_o,
    output logic [31:0] mem_wb_mem_rd_data_o,
    output logic [31:0] mem_wb_alu_result_o,
    output logic [31:0] mem_wb_pc_plus4_o,
    output logic        rf_wr_en_o,
    output logic [4:0]  rf_wr_addr_o,
    output logic [31:0] rf_wr_data_o
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_WAIT  = 2'b01;
    localparam logic [1:0] ST_ABORT = 2'b10;

    localparam logic [1:0] DEST_ALU = 2'b00;
    localparam logic [1:0] DEST_MEM = 2'b01;
    localparam logic [1:0] DEST_PC  = 2'b10;

    typedef struct packed {
        logic        valid;
        logic [4:0]  wr_addr;
        logic        wr_sig;
        logic [1:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc_plus4;
        logic [31:0] mem_wr_data;
        logic        mem_rd;
        logic        mem_wr;
    } ex_mem_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  wr_addr;
        logic        wr_sig;
        logic [1:0]  dest;
        logic [31:0] mem_rd_data;
        logic [31:0] alu_result;
        logic [31:0] pc_plus4;
    } mem_wb_t;

    ex_mem_t          exm_q, exm_d;
    mem_wb_t          wb_q, wb_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic mem_op;
    logic abort;
    logic stall;

    assign mem_op = exm_q.valid & (exm_q.mem_rd | exm_q.mem_wr);
    assign abort  = (state_q == ST_ABORT);
    assign stall  = mem_op & ~dmem_ready_i & ~abort;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_op && !dmem_ready_i) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (dmem_ready_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                    // counter reaches MEM_TIMEOUT exactly as ABORT is entered
                    if (int'(cnt_q) + 1 >= MEM_TIMEOUT) state_d = ST_ABORT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        exm_d = exm_q;
        if (!stall) begin
            exm_d.valid       = ex_valid_i & ~flush_i;
            exm_d.wr_addr     = ex_reg_wr_addr_i;
            exm_d.wr_sig      = ex_reg_wr_sig_i;
            exm_d.dest        = ex_data_dest_i;
            exm_d.alu_result  = ex_alu_result_i;
            exm_d.pc_plus4    = ex_pc_plus4_i;
            exm_d.mem_wr_data = ex_mem_wr_data_i;
            exm_d.mem_rd      = ex_mem_rd_i;
            exm_d.mem_wr      = ex_mem_wr_i;
        end
    end

    // Stores and timed-out accesses drop their write enable on the way into MEM/WB.
    always_comb begin
        wb_d = '0;
        if (!stall) begin
            wb_d.valid       = exm_q.valid;
            wb_d.wr_addr     = exm_q.wr_addr;
            wb_d.wr_sig      = exm_q.wr_sig & ~exm_q.mem_wr & ~abort;
            wb_d.dest        = exm_q.dest;
            wb_d.alu_result  = exm_q.alu_result;
            wb_d.pc_plus4    = exm_q.pc_plus4;
            wb_d.mem_rd_data = (exm_q.valid & exm_q.mem_rd & ~abort) ? dmem_rdata_i : 32'h0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            exm_q   <= '0;
            wb_q    <= '0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            exm_q   <= exm_d;
            wb_q    <= wb_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_o      = stall;
    assign dmem_err_o   = abort;
    assign dmem_req_o   = mem_op & ~abort;
    assign dmem_we_o    = mem_op & ~abort & exm_q.mem_wr;
    assign dmem_addr_o  = (mem_op & ~abort) ? exm_q.alu_result : 32'h0;
    assign dmem_wdata_o = (mem_op & ~abort) ? exm_q.mem_wr_data : 32'h0;

    assign ex_mem_reg_wr_addr_o = exm_q.wr_addr;
    assign ex_mem_reg_wr_sig_o  = exm_q.valid & exm_q.wr_sig;
    assign ex_mem_data_dest_o   = exm_q.dest;
    assign ex_mem_alu_result_o  = exm_q.alu_result;
    assign ex_mem_pc_plus4_o    = exm_q.pc_plus4;

    assign mem_wb_reg_wr_addr_o = wb_q.wr_addr;
    assign mem_wb_reg_wr_sig_o  = wb_q.valid & wb_q.wr_sig;
    assign mem_wb_data_dest_o   = wb_q.dest;
    assign mem_wb_mem_rd_data_o = wb_q.mem_rd_data;
    assign mem_wb_alu_result_o  = wb_q.alu_result;
    assign mem_wb_pc_plus4_o    = wb_q.pc_plus4;

    assign rf_wr_en_o   = wb_q.valid & wb_q.wr_sig & (wb_q.wr_addr != 5'd0) & (wb_q.dest != 2'b11);
    assign rf_wr_addr_o = wb_q.wr_addr;

    always_comb begin
        case (wb_q.dest)
            DEST_ALU: rf_wr_data_o = wb_q.alu_result;
            DEST_MEM: rf_wr_data_o = wb_q.mem_rd_data;
            DEST_PC:  rf_wr_data_o = wb_q.pc_plus4;
            default:  rf_wr_data_o = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_mem_wb_pipeline.sv
// Directed scenarios plus a randomized instruction stream checked against a
// transaction-level model of the MEM stage (latency per access, timeout limit, writeback rules).
module tb_mem_wb_pipeline;

    localparam int T = 15;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ex_valid_i;
    logic [4:0]  ex_reg_wr_addr_i;
    logic        ex_reg_wr_sig_i;
    logic [1:0]  ex_data_dest_i;
    logic [31:0] ex_alu_result_i, ex_pc_plus4_i, ex_mem_wr_data_i;
    logic        ex_mem_rd_i, ex_mem_wr_i, flush_i;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic        dmem_ready_i;
    logic [31:0] dmem_rdata_i;
    logic        stall_o, dmem_err_o;
    logic [4:0]  ex_mem_reg_wr_addr_o;
    logic        ex_mem_reg_wr_sig_o;
    logic [1:0]  ex_mem_data_dest_o;
    logic [31:0] ex_mem_alu_result_o, ex_mem_pc_plus4_o;
    logic [4:0]  mem_wb_reg_wr_addr_o;
    logic        mem_wb_reg_wr_sig_o;
    logic [1:0]  mem_wb_data_dest_o;
    logic [31:0] mem_wb_mem_rd_data_o, mem_wb_alu_result_o, mem_wb_pc_plus4_o;
    logic        rf_wr_en_o;
    logic [4:0]  rf_wr_addr_o;
    logic [31:0] rf_wr_data_o;

    int n_tests = 0;
    int n_fail  = 0;

    mem_wb_pipeline #(.MEM_TIMEOUT(T)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ex_valid_i(ex_valid_i), .ex_reg_wr_addr_i(ex_reg_wr_addr_i),
        .ex_reg_wr_sig_i(ex_reg_wr_sig_i), .ex_data_dest_i(ex_data_dest_i),
        .ex_alu_result_i(ex_alu_result_i), .ex_pc_plus4_i(ex_pc_plus4_i),
        .ex_mem_wr_data_i(ex_mem_wr_data_i), .ex_mem_rd_i(ex_mem_rd_i),
        .ex_mem_wr_i(ex_mem_wr_i), .flush_i(flush_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_ready_i(dmem_ready_i), .dmem_rdata_i(dmem_rdata_i),
        .stall_o(stall_o), .dmem_err_o(dmem_err_o),
        .ex_mem_reg_wr_addr_o(ex_mem_reg_wr_addr_o), .ex_mem_reg_wr_sig_o(ex_mem_reg_wr_sig_o),
        .ex_mem_data_dest_o(ex_mem_data_dest_o), .ex_mem_alu_result_o(ex_mem_alu_result_o),
        .ex_mem_pc_plus4_o(ex_mem_pc_plus4_o),
        .mem_wb_reg_wr_addr_o(mem_wb_reg_wr_addr_o), .mem_wb_reg_wr_sig_o(mem_wb_reg_wr_sig_o),
        .mem_wb_data_dest_o(mem_wb_data_dest_o), .mem_wb_mem_rd_data_o(mem_wb_mem_rd_data_o),
        .mem_wb_alu_result_o(mem_wb_alu_result_o), .mem_wb_pc_plus4_o(mem_wb_pc_plus4_o),
        .rf_wr_en_o(rf_wr_en_o), .rf_wr_addr_o(rf_wr_addr_o), .rf_wr_data_o(rf_wr_data_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          valid;
        bit          flush;
        logic [4:0]  addr;
        bit          sig;
        logic [1:0]  dest;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [31:0] wdata;
        bit          rd;
        bit          wr;
        int          lat;
        logic [31:0] rdata;
    } instr_t;

    task automatic drive(input bit v, input logic [4:0] a, input bit s, input logic [1:0] d,
                         input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] wd,
                         input bit rd, input bit wr, input bit fl);
        ex_valid_i = v; ex_reg_wr_addr_i = a; ex_reg_wr_sig_i = s; ex_data_dest_i = d;
        ex_alu_result_i = alu; ex_pc_plus4_i = pc4; ex_mem_wr_data_i = wd;
        ex_mem_rd_i = rd; ex_mem_wr_i = wr; flush_i = fl;
    endtask

    task automatic drive_idle();
        drive(0, 5'd0, 0, 2'd0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1; drive_idle(); dmem_ready_i = 1'b0; dmem_rdata_i = 32'h0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_tests++;
        if ({dmem_req_o, dmem_we_o, stall_o, dmem_err_o, rf_wr_en_o} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: req/we/stall/err/rf_en=%b required 00000",
                     {dmem_req_o, dmem_we_o, stall_o, dmem_err_o, rf_wr_en_o});
        end
        n_tests++;
        if ({ex_mem_reg_wr_sig_o, mem_wb_reg_wr_sig_o, dmem_addr_o, rf_wr_data_o, ex_mem_alu_result_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: exm_sig=%b wb_sig=%b addr=%h rf_data=%h exm_alu=%h required all 0",
                     ex_mem_reg_wr_sig_o, mem_wb_reg_wr_sig_o, dmem_addr_o, rf_wr_data_o, ex_mem_alu_result_o);
        end
        $display("[TB] reset: outputs checked after reset release");
    endtask

    task automatic test_back_to_back();
        logic [31:0] v6;
        v6 = $urandom;
        @(negedge clk_i); drive(1, 5'd5, 1, 2'b00, 32'h10, 32'h4, 32'h0, 0, 0, 0);
        @(negedge clk_i); drive(1, 5'd6, 1, 2'b00, v6, 32'h8, 32'h0, 0, 0, 0);
        #1;
        n_tests++;
        if (ex_mem_reg_wr_addr_o !== 5'd5 || ex_mem_reg_wr_sig_o !== 1'b1 || ex_mem_alu_result_o !== 32'h10 || stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_exmem: addr=%0d sig=%b alu=%h stall=%b required 5 1 00000010 0",
                     ex_mem_reg_wr_addr_o, ex_mem_reg_wr_sig_o, ex_mem_alu_result_o, stall_o);
        end
        @(negedge clk_i); drive_idle(); #1;
        n_tests++;
        if (rf_wr_en_o !== 1'b1 || rf_wr_addr_o !== 5'd5 || rf_wr_data_o !== 32'h10 || stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_wb_x5: en=%b addr=%0d data=%h stall=%b required 1 5 00000010 0",
                     rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o, stall_o);
        end
        @(negedge clk_i); #1;
        n_tests++;
        if (rf_wr_en_o !== 1'b1 || rf_wr_addr_o !== 5'd6 || rf_wr_data_o !== v6) begin
            n_fail++;
            $display("FAIL alu_wb_x6: en=%b addr=%0d data=%h required 1 6 %h", rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o, v6);
        end
        $display("[TB] back_to_back: x5=00000010 x6=%h", v6);
    endtask

    task automatic test_load_wait();
        int stalls = 0;
        @(negedge clk_i); drive(1, 5'd7, 1, 2'b01, 32'h100, 32'h0, 32'h0, 1, 0, 0); dmem_ready_i = 0;
        @(negedge clk_i); drive_idle(); #1;
        n_tests++;
        if (dmem_req_o !== 1'b1 || dmem_we_o !== 1'b0 || dmem_addr_o !== 32'h100) begin
            n_fail++;
            $display("FAIL load_req: req=%b we=%b addr=%h required 1 0 00000100", dmem_req_o, dmem_we_o, dmem_addr_o);
        end
        for (int c = 0; c < 3; c++) begin
            if (c > 0) begin @(negedge clk_i); #1; end
            if (stall_o === 1'b1) stalls++;
            n_tests++;
            if (rf_wr_en_o !== 1'b0 || mem_wb_reg_wr_sig_o !== 1'b0) begin
                n_fail++;
                $display("FAIL load_bubble: cycle=%0d rf_en=%b wb_sig=%b required 0 0", c, rf_wr_en_o, mem_wb_reg_wr_sig_o);
            end
        end
        @(negedge clk_i); dmem_ready_i = 1; dmem_rdata_i = 32'hDEADBEEF; #1;
        n_tests++;
        if (stalls != 3 || stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL load_stall: stall_cycles=%0d stall_on_ready=%b required 3 0", stalls, stall_o);
        end
        @(negedge clk_i); dmem_ready_i = 0; dmem_rdata_i = 32'h0; #1;
        n_tests++;
        if (rf_wr_en_o !== 1'b1 || rf_wr_addr_o !== 5'd7 || rf_wr_data_o !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL load_wb: en=%b addr=%0d data=%h required 1 7 deadbeef", rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o);
        end
        $display("[TB] load_wait: x7 <- [00000100] after %0d stall cycles", stalls);
    endtask

    task automatic test_store();
        @(negedge clk_i); drive(1, 5'd9, 1, 2'b00, 32'h200, 32'h0, 32'h12345678, 0, 1, 0);
        @(negedge clk_i); drive_idle(); dmem_ready_i = 1; #1;
        n_tests++;
        if (dmem_req_o !== 1'b1 || dmem_we_o !== 1'b1 || dmem_addr_o !== 32'h200 ||
            dmem_wdata_o !== 32'h12345678 || stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL store_req: req=%b we=%b addr=%h wdata=%h stall=%b required 1 1 00000200 12345678 0",
                     dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, stall_o);
        end
        @(negedge clk_i); dmem_ready_i = 0; #1;
        n_tests++;
        if (rf_wr_en_o !== 1'b0 || dmem_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL store_wb: rf_en=%b req=%b required 0 0", rf_wr_en_o, dmem_req_o);
        end
        $display("[TB] store: [00000200] <- 12345678");
    endtask

    task automatic test_timeout();
        int stalls = 0;
        bit done = 0;
        @(negedge clk_i); drive(1, 5'd8, 1, 2'b01, 32'h300, 32'h0, 32'h0, 1, 0, 0); dmem_ready_i = 0;
        @(negedge clk_i); drive(1, 5'd9, 1, 2'b00, 32'h99, 32'h0, 32'h0, 0, 0, 0);
        for (int c = 0; c < 40 && !done; c++) begin
            if (c > 0) @(negedge clk_i);
            #1;
            if (stall_o === 1'b1) stalls++;
            else done = 1;
        end
        n_tests++;
        if (!done || stalls != T || dmem_err_o !== 1'b1 || dmem_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_abort: ended=%b stall_cycles=%0d err=%b req=%b required 1 %0d 1 0",
                     done, stalls, dmem_err_o, dmem_req_o, T);
        end
        @(negedge clk_i); drive_idle(); #1;
        n_tests++;
        if (rf_wr_en_o !== 1'b0 || dmem_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_nowrite: rf_en=%b err=%b required 0 0", rf_wr_en_o, dmem_err_o);
        end
        @(negedge clk_i); #1;
        n_tests++;
        if (rf_wr_en_o !== 1'b1 || rf_wr_addr_o !== 5'd9 || rf_wr_data_o !== 32'h99) begin
            n_fail++;
            $display("FAIL timeout_next: en=%b addr=%0d data=%h required 1 9 00000099", rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o);
        end
        $display("[TB] timeout: load aborted after %0d stall cycles", stalls);
    endtask

    task automatic test_jal_flush();
        @(negedge clk_i); drive(1, 5'd1, 1, 2'b10, 32'h1000, 32'h44, 32'h0, 0, 0, 0);
        @(negedge clk_i); drive(1, 5'd3, 1, 2'b00, 32'h33, 32'h48, 32'h0, 0, 0, 1);
        @(negedge clk_i); drive_idle(); #1;
        n_tests++;
        if (rf_wr_en_o !== 1'b1 || rf_wr_addr_o !== 5'd1 || rf_wr_data_o !== 32'h44 || ex_mem_reg_wr_sig_o !== 1'b0) begin
            n_fail++;
            $display("FAIL jal_wb: en=%b addr=%0d data=%h exm_sig=%b required 1 1 00000044 0",
                     rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o, ex_mem_reg_wr_sig_o);
        end
        @(negedge clk_i); #1;
        n_tests++;
        if (rf_wr_en_o !== 1'b0 || mem_wb_reg_wr_sig_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_nowrite: rf_en=%b wb_sig=%b required 0 0", rf_wr_en_o, mem_wb_reg_wr_sig_o);
        end
        $display("[TB] jal_flush: x1 <- 00000044, flushed x3 dropped");
    endtask

    task automatic test_x0_and_reset_wait();
        int bad = 0;
        @(negedge clk_i); drive(1, 5'd0, 1, 2'b00, 32'hFFFF, 32'h0, 32'h0, 0, 0, 0);
        @(negedge clk_i); drive_idle();
        @(negedge clk_i); #1;
        n_tests++;
        if (rf_wr_en_o !== 1'b0 || mem_wb_reg_wr_sig_o !== 1'b1) begin
            n_fail++;
            $display("FAIL x0_write: rf_en=%b wb_sig=%b required 0 1", rf_wr_en_o, mem_wb_reg_wr_sig_o);
        end
        @(negedge clk_i); drive(1, 5'd10, 1, 2'b01, 32'h400, 32'h0, 32'h0, 1, 0, 0); dmem_ready_i = 0;
        @(negedge clk_i); drive_idle();
        repeat (4) @(negedge clk_i);
        #1;
        n_tests++;
        if (stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_wait_pre: stall=%b required 1", stall_o);
        end
        @(negedge clk_i); rst_i = 1;
        @(negedge clk_i); rst_i = 0;
        for (int c = 0; c < T + 5; c++) begin
            #1;
            if (rf_wr_en_o !== 1'b0 || dmem_err_o !== 1'b0 || dmem_req_o !== 1'b0 || stall_o !== 1'b0) bad++;
            @(negedge clk_i);
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rst_wait_post: cycles_with_activity=%0d required 0", bad);
        end
        $display("[TB] x0_and_reset_wait: x0 write suppressed, access abandoned by reset");
    endtask

    function automatic instr_t gen();
        instr_t i;
        int op;
        op = $urandom_range(0, 3);
        i.valid = ($urandom_range(0, 9) != 0);
        i.flush = ($urandom_range(0, 6) == 0);
        i.addr  = 5'($urandom_range(0, 31));
        i.sig   = ($urandom_range(0, 4) != 0);
        i.alu   = $urandom;
        i.pc4   = $urandom;
        i.wdata = $urandom;
        i.rdata = $urandom;
        i.rd    = (op == 1);
        i.wr    = (op == 2);
        i.dest  = (op == 1) ? 2'b01 : (op == 3) ? 2'b10 : 2'($urandom_range(0, 3));
        i.lat   = ($urandom_range(0, 7) == 0) ? $urandom_range(T - 1, T + 2) : $urandom_range(0, 3);
        return i;
    endfunction

    // Model: an access presented for `lat` cycles completes if lat < T, otherwise it
    // occupies T stall cycles and is aborted on the next one.
    task automatic test_random();
        instr_t cur, pend;
        int k = 0, issued = 0, bad = 0, writes = 0, aborts = 0;
        bit exp_en = 0, memop, rdy, abort_cyc, exp_stall;
        logic [4:0] exp_addr = 0;
        logic [31:0] exp_data = 0;
        cur = gen(); cur.valid = 0;
        pend = gen();
        while (issued < 400) begin
            @(negedge clk_i);
            drive(pend.valid, pend.addr, pend.sig, pend.dest, pend.alu, pend.pc4, pend.wdata,
                  pend.rd, pend.wr, pend.flush);
            memop     = cur.valid && (cur.rd || cur.wr);
            abort_cyc = memop && cur.lat >= T && k == T;
            rdy       = memop && cur.lat < T && k == cur.lat;
            exp_stall = memop && !rdy && !abort_cyc;
            dmem_ready_i = rdy;
            dmem_rdata_i = rdy ? cur.rdata : $urandom;
            #1;
            n_tests++;
            if (stall_o !== exp_stall || dmem_err_o !== abort_cyc || dmem_req_o !== (memop && !abort_cyc) ||
                (dmem_req_o === 1'b1 && (dmem_addr_o !== cur.alu || dmem_we_o !== cur.wr ||
                                         (cur.wr && dmem_wdata_o !== cur.wdata))) ||
                rf_wr_en_o !== exp_en || (exp_en && (rf_wr_addr_o !== exp_addr || rf_wr_data_o !== exp_data))) begin
                n_fail++; bad++;
                if (bad <= 10)
                    $display("FAIL random_cycle: issued=%0d stall=%b/%b err=%b/%b req=%b/%b addr=%h/%h rf_en=%b/%b rf=%0d:%h/%0d:%h (actual/required)",
                             issued, stall_o, exp_stall, dmem_err_o, abort_cyc, dmem_req_o, memop && !abort_cyc,
                             dmem_addr_o, cur.alu, rf_wr_en_o, exp_en, rf_wr_addr_o, rf_wr_data_o, exp_addr, exp_data);
            end
            if (!exp_stall) begin
                exp_en   = cur.valid && cur.sig && cur.addr != 0 && cur.dest != 2'b11 && !cur.wr && !abort_cyc;
                exp_addr = cur.addr;
                case (cur.dest)
                    2'b00:   exp_data = cur.alu;
                    2'b01:   exp_data = cur.rd ? cur.rdata : 32'h0;
                    default: exp_data = cur.pc4;
                endcase
                if (exp_en) writes++;
                if (abort_cyc) aborts++;
                cur = pend;
                cur.valid = pend.valid && !pend.flush;
                pend = gen();
                k = 0;
                issued++;
            end else begin
                exp_en = 0;
                k++;
            end
        end
        $display("[TB] random: %0d instructions, %0d writes, %0d aborts, %0d bad cycles", issued, writes, aborts, bad);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; drive_idle(); dmem_ready_i = 1'b0; dmem_rdata_i = 32'h0;
        test_reset();
        test_back_to_back();
        test_load_wait();
        test_store();
        test_timeout();
        test_jal_flush();
        test_x0_and_reset_wait();
        do_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wb_pipeline.md
MEM_WB_PIPELINE -- requirements
Module: mem_wb_pipeline

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: maximum wait cycles for dmem_ready_i before a load/store aborts.
REQ-002 Data-destination encoding: ALU = 2'b00, MEM = 2'b01, PC = 2'b10; 2'b11 means no writeback.
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  in  1  synchronous, active-high reset.
REQ-005 ex_valid_i  in  1  the EX stage holds a real instruction.
REQ-006 ex_reg_wr_addr_i / ex_reg_wr_sig_i / ex_data_dest_i  in  5/1/2  destination register, write enable, result source.
REQ-007 ex_alu_result_i / ex_pc_plus4_i / ex_mem_wr_data_i  in  32 each  ALU result (also the memory address), PC+4, store data.
REQ-008 ex_mem_rd_i / ex_mem_wr_i  in  1 each  word load / word store request.
REQ-009 flush_i  in  1  discard the instruction presented by EX this cycle.
REQ-010 dmem_req_o / dmem_we_o  out  1 each  memory request / write enable.
REQ-011 dmem_addr_o / dmem_wdata_o  out  32 each  memory address / store data.
REQ-012 dmem_ready_i  in  1  memory completes the current request this cycle.
REQ-013 dmem_rdata_i  in  32  load data, valid when dmem_ready_i = 1.
REQ-014 stall_o  out  1  freezes the upstream stages.
REQ-015 dmem_err_o  out  1  one-cycle pulse when an access times out.
REQ-016 ex_mem_reg_wr_addr_o / ex_mem_reg_wr_sig_o / ex_mem_data_dest_o / ex_mem_alu_result_o / ex_mem_pc_plus4_o  out  5/1/2/32/32  EX/MEM forwarding bundle.
REQ-017 mem_wb_reg_wr_addr_o / mem_wb_reg_wr_sig_o / mem_wb_data_dest_o / mem_wb_mem_rd_data_o / mem_wb_alu_result_o / mem_wb_pc_plus4_o  out  5/1/2/32/32/32  MEM/WB forwarding bundle.
REQ-018 rf_wr_en_o / rf_wr_addr_o / rf_wr_data_o  out  1/5/32  register-file write port.

Function
REQ-019 The EX/MEM register captures all ex_* inputs with valid = ex_valid_i & ~flush_i when stall_o = 0, and holds its contents when stall_o = 1.
REQ-020 The mem-op condition is EX/MEM valid & (mem_rd | mem_wr); when this condition holds and the state is not ABORT, dmem_req_o = 1, dmem_we_o = mem_wr, dmem_addr_o = alu_result, and dmem_wdata_o = the held store data; otherwise all four outputs are 0.
REQ-021 The FSM has three states: IDLE, WAIT, and ABORT.
REQ-022 In IDLE, with a mem op and dmem_ready_i = 1, the access completes in zero extra cycles and the state stays IDLE.
REQ-023 In IDLE, with a mem op and dmem_ready_i = 0, the FSM moves to WAIT and the counter loads 1.
REQ-024 In WAIT, dmem_ready_i = 1 completes the access and returns the FSM to IDLE.
REQ-025 In WAIT, with dmem_ready_i = 0, the counter increments; when the counter equals MEM_TIMEOUT, the FSM moves to ABORT.
REQ-026 ABORT lasts exactly one cycle: dmem_err_o = 1, dmem_req_o = 0, the instruction advances with reg_wr_sig forced to 0, and the FSM returns to IDLE.
REQ-027 stall_o = mem op & ~dmem_ready_i & (state ≠ ABORT); stall_o is combinational.
REQ-028 When stall_o = 0, MEM/WB captures EX/MEM, with mem_rd_data taken from dmem_rdata_i for loads and 0 otherwise.
REQ-029 When stall_o = 1, MEM/WB loads a bubble (valid = 0).
REQ-030 ex_mem_reg_wr_sig_o and mem_wb_reg_wr_sig_o are gated by their stage valid, so bubbles never forward.
REQ-031 rf_wr_en_o = MEM/WB valid & reg_wr_sig & (addr ≠ 0) & (dest ≠ 2'b11).
REQ-032 rf_wr_data_o is selected by data_dest: alu_result, mem_rd_data, pc_plus4, or 0.
REQ-033 flush_i asserted during a stall does not touch the held EX/MEM instruction, which completes normally.
REQ-034 A store never asserts rf_wr_en_o, regardless of reg_wr_sig.
REQ-035 The counter width is clog2(MEM_TIMEOUT+1); the counter saturates and never wraps.

Reset
REQ-036 While rst_i = 1 at a clock edge, both stage registers clear to 0 (valid = 0), the FSM enters IDLE, and the counter clears to 0.
REQ-037 The cycle after reset, all outputs are 0, including dmem_req_o, stall_o, dmem_err_o, and rf_wr_en_o.
REQ-038 Reset asserted in WAIT abandons the access: there is no dmem_err_o pulse and no register write.

Verification
REQ-039 ALU op x5 = 0x00000010 (dest ALU), back-to-back -> ex_mem bundle valid at cycle 1, rf write x5 = 0x10 at cycle 2, stall_o = 0 throughout.
REQ-040 Load x7 at address 0x100, dmem_ready_i low for 3 cycles then high with rdata 0xDEADBEEF -> stall_o high for 3 cycles, 3 MEM/WB bubbles, then rf write x7 = 0xDEADBEEF.
REQ-041 Store at 0x200 with data 0x12345678 and dmem_ready_i immediately high -> dmem_we_o = 1, dmem_wdata_o = 0x12345678, no stall, rf_wr_en_o = 0.
REQ-042 Load with dmem_ready_i never asserted, MEM_TIMEOUT = 15 -> stall for 15 cycles, dmem_err_o pulse, no rf write, next instruction proceeds.
REQ-043 JAL-type instruction to x1 with pc_plus4 0x44 and flush_i on the following instruction -> rf write x1 = 0x44; the flushed instruction produces no write.
REQ-044 Write to x0, and reset asserted mid-WAIT -> rf_wr_en_o = 0 in both cases; after reset, dmem_req_o = 0.
